thread_run_control: RTL

Per-thread run/halt sequencer for the branching Controller. It accepts start/halt commands addressed to individual threads. It tracks the round-robin issue slot, and on each thread's slot drives the Controller's `jump`, `jump_destination` and `cancel` inputs. A started thread begins fetching at a commanded PC. A halted thread is pinned to a per-thread park address until it is restarted.

---
 rtl/thread_run_control_pkg.sv | 14 +
 rtl/thread_run_control_slot.sv | 31 +++
 rtl/thread_run_control.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/thread_run_control_pkg.sv
// Shared definitions for the per-thread run/halt sequencer: command encoding
// and FSM state encoding.
package thread_run_control_pkg;

    localparam logic CMD_START = 1'b0;
    localparam logic CMD_HALT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_APPLY = 2'd2
    } run_state_e;

endpackage

// File: rtl/thread_run_control_slot.sv
// Round-robin issue-slot counter (thread number with synchronous active-low reset).
// Exposes both the registered slot and the slot that will be presented next cycle.
module thread_run_control_slot #(
    parameter int THREAD_COUNT       = 8,
    parameter int THREAD_COUNT_WIDTH = 3
) (
    input  logic                          clock,
    input  logic                          reset_n,
    output logic [THREAD_COUNT_WIDTH-1:0] slot,
    output logic [THREAD_COUNT_WIDTH-1:0] slot_next
);

    localparam logic [THREAD_COUNT_WIDTH-1:0] LAST_SLOT = THREAD_COUNT_WIDTH'(THREAD_COUNT - 1);

    logic [THREAD_COUNT_WIDTH-1:0] slot_reg;

    always_comb begin
        slot_next = (slot_reg == LAST_SLOT) ? '0 : slot_reg + THREAD_COUNT_WIDTH'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            slot_reg <= '0;
        end else begin
            slot_reg <= slot_next;
        end
    end

    assign slot = slot_reg;

endmodule

// File: rtl/thread_run_control.sv
// Per-thread run/halt sequencer driving the Controller's jump/cancel on each thread's slot.
// Optional feature: define RUN_CONTROL_AUTOSTART_EN to have every thread active out of reset.
module thread_run_control
    import thread_run_control_pkg::*;
#(
    parameter int PC_WIDTH           = 10,
    parameter int THREAD_COUNT       = 8,
    parameter int THREAD_COUNT_WIDTH = 3
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_halt,
    input  logic [THREAD_COUNT_WIDTH-1:0] cmd_thread,
    input  logic [PC_WIDTH-1:0]           cmd_pc,
    output logic [THREAD_COUNT_WIDTH-1:0] slot_thread,
    output logic                          jump,
    output logic [PC_WIDTH-1:0]           jump_destination,
    output logic                          cancel,
    output logic [THREAD_COUNT-1:0]       thread_active
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] WAIT  = ST_WAIT;
    localparam logic [1:0] APPLY = ST_APPLY;

`ifdef RUN_CONTROL_AUTOSTART_EN
    localparam logic [THREAD_COUNT-1:0] ACTIVE_RESET = '1;
`else
    localparam logic [THREAD_COUNT-1:0] ACTIVE_RESET = THREAD_COUNT'(1);
`endif

    logic [THREAD_COUNT_WIDTH-1:0] slot_reg;
    logic [THREAD_COUNT_WIDTH-1:0] slot_next;

    logic [1:0]                    state_reg;
    logic [1:0]                    state_next;
    logic                          cmd_ready_reg;
    logic                          cmd_halt_reg;
    logic [THREAD_COUNT_WIDTH-1:0] cmd_thread_reg;
    logic [PC_WIDTH-1:0]           cmd_pc_reg;

    logic                          jump_reg;
    logic                          jump_next;
    logic                          cancel_reg;
    logic                          cancel_next;
    logic [PC_WIDTH-1:0]           dest_reg;
    logic [PC_WIDTH-1:0]           dest_next;

    logic [THREAD_COUNT-1:0]       active_reg;
    logic [PC_WIDTH-1:0]           park_reg [THREAD_COUNT];

    logic                          accept;
    logic                          present_next;
    logic [PC_WIDTH-1:0]           apply_pc;

    thread_run_control_slot #(
        .THREAD_COUNT       (THREAD_COUNT),
        .THREAD_COUNT_WIDTH (THREAD_COUNT_WIDTH)
    ) u_slot (
        .clock     (clock),
        .reset_n   (reset_n),
        .slot      (slot_reg),
        .slot_next (slot_next)
    );

    assign accept = cmd_valid && (state_reg == IDLE);

    // A command whose thread is the very next slot skips WAIT entirely, so
    // exact-slot acceptance applies one cycle later without a full wrap.
    always_comb begin
        state_next   = state_reg;
        present_next = 1'b0;
        apply_pc     = cmd_pc_reg;
        case (state_reg)
            IDLE: begin
                apply_pc = cmd_pc;
                if (accept) begin
                    present_next = (slot_next == cmd_thread);
                    state_next   = present_next ? APPLY : WAIT;
                end
            end
            WAIT: begin
                present_next = (slot_next == cmd_thread_reg);
                state_next   = present_next ? APPLY : WAIT;
            end
            APPLY:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        jump_next   = 1'b0;
        cancel_next = 1'b0;
        dest_next   = '0;
        if (present_next) begin
            jump_next   = 1'b1;
            cancel_next = 1'b1;
            dest_next   = apply_pc;
        end else if (!active_reg[slot_next]) begin
            jump_next   = 1'b1;
            cancel_next = 1'b1;
            dest_next   = park_reg[slot_next];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            cmd_ready_reg  <= 1'b1;
            cmd_halt_reg   <= CMD_START;
            cmd_thread_reg <= '0;
            cmd_pc_reg     <= '0;
            jump_reg       <= 1'b0;
            cancel_reg     <= 1'b0;
            dest_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= (state_next == IDLE);
            if (accept) begin
                cmd_halt_reg   <= cmd_halt;
                cmd_thread_reg <= cmd_thread;
                cmd_pc_reg     <= cmd_pc;
            end
            jump_reg   <= jump_next;
            cancel_reg <= cancel_next;
            dest_reg   <= dest_next;
        end
    end

    // Run state and park address change only at the end of the APPLY cycle.
    for (genvar gi = 0; gi < THREAD_COUNT; gi++) begin : g_thread
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                active_reg[gi] <= ACTIVE_RESET[gi];
                park_reg[gi]   <= '0;
            end else if ((state_reg == APPLY) && (cmd_thread_reg == THREAD_COUNT_WIDTH'(gi))) begin
                active_reg[gi] <= (cmd_halt_reg != CMD_HALT);
                if (cmd_halt_reg == CMD_HALT) begin
                    park_reg[gi] <= cmd_pc_reg;
                end
            end
        end
    end

    assign cmd_ready        = cmd_ready_reg;
    assign slot_thread      = slot_reg;
    assign jump             = jump_reg;
    assign cancel           = cancel_reg;
    assign jump_destination = dest_reg;
    assign thread_active    = active_reg;

endmodule
